// File: rtl/fft_cbfp_align.sv
// Collects frames of per-beat CBFP-normalised lanes into a ping-pong buffer,
// then replays each frame rescaled to the frame-wide minimum exponent.
module fft_cbfp_align #(
    parameter int DATA  = 11,
    parameter int ARRAY = 16,
    parameter int INDEX = 5,
    parameter int BEATS = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_in,
    input  logic [INDEX-1:0]        min_in,
    input  logic signed [DATA-1:0]  din_re [ARRAY],
    input  logic signed [DATA-1:0]  din_im [ARRAY],
    output logic                    valid_out,
    output logic                    sof_out,
    output logic                    eof_out,
    output logic [INDEX-1:0]        exp_out,
    output logic signed [DATA-1:0]  dout_re [ARRAY],
    output logic signed [DATA-1:0]  dout_im [ARRAY]
);

    // Handshake: valid-only on both sides. A beat transfers on every rising edge
    // where valid_in (resp. valid_out) is high; there is no ready/backpressure.

    localparam int CW = $clog2(BEATS);

    typedef enum logic {IDLE, READ} rd_state_t;

    logic signed [DATA-1:0] mem_re [2][BEATS][ARRAY];
    logic signed [DATA-1:0] mem_im [2][BEATS][ARRAY];
    logic [INDEX-1:0]       shift_mem [2][BEATS];
    logic [INDEX-1:0]       frame_min [2];

    logic [1:0]        full, ready, set_mask, free_mask;
    logic              wr_bank, wr_last;
    logic [CW-1:0]     wr_cnt;
    logic [INDEX-1:0]  run_min, cur_min;

    rd_state_t         rd_state, rd_state_n;
    logic              rd_bank, rd_bank_n, rd_last, issue, free;
    logic [CW-1:0]     rd_cnt, rd_cnt_n;
    logic [INDEX-1:0]  sh;

    assign wr_last = valid_in && (wr_cnt == CW'(BEATS - 1));
    assign rd_last = (rd_cnt == CW'(BEATS - 1));

    always_comb begin
        cur_min = run_min;
        if (wr_cnt == '0 || min_in < run_min)
            cur_min = min_in;
    end

    // A bank counts as ready in the same cycle its last beat is written, which
    // lets the first output beat leave two cycles after the last input beat.
    assign set_mask  = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign free_mask = free ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign ready     = full | set_mask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            run_min   <= '0;
            full      <= 2'b00;
            frame_min <= '{default: '0};
        end else begin
            full <= (full & ~free_mask) | set_mask;
            if (valid_in) begin
                wr_cnt  <= wr_cnt + 1'b1;
                run_min <= cur_min;
                if (wr_last) begin
                    frame_min[wr_bank] <= cur_min;
                    wr_bank            <= ~wr_bank;
                end
            end
        end
    end

    // Bank storage is not reset; the full flags gate every read.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            mem_re[wr_bank][wr_cnt]    <= din_re;
            mem_im[wr_bank][wr_cnt]    <= din_im;
            shift_mem[wr_bank][wr_cnt] <= min_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state <= IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            rd_cnt   <= rd_cnt_n;
            rd_bank  <= rd_bank_n;
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_cnt_n   = rd_cnt;
        rd_bank_n  = rd_bank;
        issue      = 1'b0;
        free       = 1'b0;
        case (rd_state)
            IDLE: begin
                rd_cnt_n = '0;
                if (ready[rd_bank])
                    rd_state_n = READ;
            end
            READ: begin
                issue    = 1'b1;
                rd_cnt_n = rd_cnt + 1'b1;
                if (rd_last) begin
                    free       = 1'b1;
                    rd_bank_n  = ~rd_bank;
                    rd_cnt_n   = '0;
                    rd_state_n = ready[~rd_bank] ? READ : IDLE;
                end
            end
            default: rd_state_n = IDLE;
        endcase
    end

    // Beat shift minus frame minimum is never negative; shifts past the lane
    // width collapse to pure sign fill.
    assign sh = shift_mem[rd_bank][rd_cnt] - frame_min[rd_bank];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
            exp_out   <= '0;
            dout_re   <= '{default: '0};
            dout_im   <= '{default: '0};
        end else begin
            valid_out <= issue;
            sof_out   <= issue && (rd_cnt == '0);
            eof_out   <= issue && rd_last;
            if (issue) begin
                exp_out <= frame_min[rd_bank];
                for (int j = 0; j < ARRAY; j++) begin
                    dout_re[j] <= mem_re[rd_bank][rd_cnt][j] >>> sh;
                    dout_im[j] <= mem_im[rd_bank][rd_cnt][j] >>> sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_cbfp_align.sv
// Randomised bench for fft_cbfp_align: frames are modelled as whole arrays,
// rescaled by floor division, and stamped with their required output cycle.
module tb_fft_cbfp_align;

    localparam int DATA  = 11;
    localparam int ARRAY = 16;
    localparam int INDEX = 5;
    localparam int BEATS = 32;

    typedef logic signed [DATA-1:0] lanes_t [ARRAY];
    typedef struct packed {
        logic [31:0]             cyc;
        logic                    sof;
        logic                    eof;
        logic [INDEX-1:0]        expo;
        logic [ARRAY*DATA-1:0]   re;
        logic [ARRAY*DATA-1:0]   im;
    } beat_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             valid_in = 1'b0;
    logic [INDEX-1:0] min_in = '0;
    lanes_t           din_re, din_im, dout_re, dout_im;
    logic             valid_out, sof_out, eof_out;
    logic [INDEX-1:0] exp_out;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t cap_q[$];
    int    f_re [BEATS][ARRAY];
    int    f_im [BEATS][ARRAY];
    int    f_min [BEATS];

    fft_cbfp_align #(.DATA(DATA), .ARRAY(ARRAY), .INDEX(INDEX), .BEATS(BEATS)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .min_in(min_in),
        .din_re(din_re), .din_im(din_im),
        .valid_out(valid_out), .sof_out(sof_out), .eof_out(eof_out), .exp_out(exp_out),
        .dout_re(dout_re), .dout_im(dout_im)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ARRAY*DATA-1:0] pack(input lanes_t l);
        logic [ARRAY*DATA-1:0] v;
        for (int j = 0; j < ARRAY; j++) v[j*DATA +: DATA] = l[j];
        return v;
    endfunction

    function automatic string fmt(input beat_t b);
        return $sformatf("cyc=%0d sof=%b eof=%b exp=%0d re=%h im=%h",
                         b.cyc, b.sof, b.eof, b.expo, b.re, b.im);
    endfunction

    // output monitor
    always @(negedge clk) begin : mon
        beat_t c;
        if (rstn === 1'b1 && valid_out === 1'b1) begin
            c.cyc  = cyc;
            c.sof  = sof_out;
            c.eof  = eof_out;
            c.expo = exp_out;
            c.re   = pack(dout_re);
            c.im   = pack(dout_im);
            cap_q.push_back(c);
        end
    end

    // reference model: value / 2^sh rounded toward -inf
    function automatic int floor_shift(input int v, input int sh);
        int d;
        if (sh >= DATA) return (v < 0) ? -1 : 0;
        d = 1 << sh;
        if (v >= 0) return v / d;
        return -(((-v) + d - 1) / d);
    endfunction

    function automatic void model_frame(input int k);
        int    fmin;
        beat_t e;
        fmin = f_min[0];
        for (int b = 1; b < BEATS; b++) if (f_min[b] < fmin) fmin = f_min[b];
        for (int b = 0; b < BEATS; b++) begin
            e.cyc  = k + 2 + b;
            e.sof  = (b == 0);
            e.eof  = (b == BEATS - 1);
            e.expo = INDEX'(fmin);
            for (int j = 0; j < ARRAY; j++) begin
                e.re[j*DATA +: DATA] = DATA'(floor_shift(f_re[b][j], f_min[b] - fmin));
                e.im[j*DATA +: DATA] = DATA'(floor_shift(f_im[b][j], f_min[b] - fmin));
            end
            exp_q.push_back(e);
        end
    endfunction

    // drivers
    task automatic fill_random(input int lo_min, input int hi_min);
        for (int b = 0; b < BEATS; b++) begin
            f_min[b] = $urandom_range(lo_min, hi_min);
            for (int j = 0; j < ARRAY; j++) begin
                f_re[b][j] = int'($urandom_range(0, 2047)) - 1024;
                f_im[b][j] = int'($urandom_range(0, 2047)) - 1024;
            end
        end
    endtask

    task automatic drive_beat(input int b);
        valid_in = 1'b1;
        min_in   = INDEX'(f_min[b]);
        for (int j = 0; j < ARRAY; j++) begin
            din_re[j] = DATA'(f_re[b][j]);
            din_im[j] = DATA'(f_im[b][j]);
        end
    endtask

    // gap_mode: 0 gap-free, 1 every other cycle, 2 random 0..2 idle cycles
    task automatic send_frame(input int gap_mode, input int nbeats, output int k);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            if (b > 0) n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (n) begin
                @(posedge clk); #1;
                valid_in = 1'b0;
            end
            @(posedge clk); #1;
            drive_beat(b);
        end
        k = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int budget = 0;
        while (cap_q.size() < n && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_out, sof_out, eof_out} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b need 000", {valid_out, sof_out, eof_out});
        end
        checks++;
        if (exp_out !== '0) begin
            errors++; $display("FAIL reset_exp: got %0d need 0", exp_out);
        end
        checks++;
        if ({pack(dout_re), pack(dout_im)} !== '0) begin
            errors++; $display("FAIL reset_data: got re=%h im=%h need 0", pack(dout_re), pack(dout_im));
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || cap_q.size() != 0) begin
            errors++; $display("FAIL reset_idle: got valid_out=%b beats=%0d need 0", valid_out, cap_q.size());
        end
    endtask

    task automatic test_uniform();
        int k; beat_t g, e;
        for (int b = 0; b < BEATS; b++) begin
            f_min[b] = 3;
            for (int j = 0; j < ARRAY; j++) begin f_re[b][j] = j; f_im[b][j] = -j; end
        end
        send_frame(0, BEATS, k); idle(); model_frame(k);
        wait_outputs(BEATS);
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            g = cap_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL uniform_beat: got %s need %s", fmt(g), fmt(e)); end
        end
        checks++;
        if (cap_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL uniform_count: got %0d extra beats, %0d missing", cap_q.size(), exp_q.size());
        end
        cap_q.delete(); exp_q.delete();
    endtask

    task automatic test_mixed();
        int k; beat_t g, e;
        for (int b = 0; b < BEATS; b++) begin
            f_min[b] = (b == 0) ? 5 : 2;
            for (int j = 0; j < ARRAY; j++) begin f_re[b][j] = 100; f_im[b][j] = -100; end
        end
        send_frame(0, BEATS, k); idle(); model_frame(k);
        wait_outputs(BEATS);
        checks++;
        if (cap_q.size() == 0 || $signed(cap_q[0].re[DATA-1:0]) != 12 || $signed(cap_q[0].im[DATA-1:0]) != -13) begin
            errors++; $display("FAIL mixed_beat0_lane0: got %s need re=12 im=-13", (cap_q.size() > 0) ? fmt(cap_q[0]) : "none");
        end
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            g = cap_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL mixed_beat: got %s need %s", fmt(g), fmt(e)); end
        end
        checks++;
        if (cap_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL mixed_count: got %0d extra beats, %0d missing", cap_q.size(), exp_q.size());
        end
        cap_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturate();
        int k; beat_t g, e;
        for (int b = 0; b < BEATS; b++) begin
            f_min[b] = (b == 1) ? 20 : 0;
            for (int j = 0; j < ARRAY; j++) begin
                f_re[b][j] = (b < 2) ? -1 : int'($urandom_range(0, 2047)) - 1024;
                f_im[b][j] = (b < 2) ? 500 : int'($urandom_range(0, 2047)) - 1024;
            end
        end
        send_frame(0, BEATS, k); idle(); model_frame(k);
        wait_outputs(BEATS);
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            g = cap_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL saturate_beat: got %s need %s", fmt(g), fmt(e)); end
        end
        checks++;
        if (cap_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL saturate_count: got %0d extra beats, %0d missing", cap_q.size(), exp_q.size());
        end
        cap_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_gaps(input int gap_mode, input int nframes);
        int k; beat_t g, e;
        for (int f = 0; f < nframes; f++) begin
            fill_random(0, 31);
            send_frame(gap_mode, BEATS, k); model_frame(k);
        end
        idle();
        wait_outputs(nframes * BEATS);
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            g = cap_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL gaps%0d_beat: got %s need %s", gap_mode, fmt(g), fmt(e)); end
        end
        checks++;
        if (cap_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL gaps%0d_count: got %0d extra beats, %0d missing", gap_mode, cap_q.size(), exp_q.size());
        end
        cap_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int k; beat_t g, e;
        fill_random(4, 4);
        send_frame(0, BEATS, k); model_frame(k);
        fill_random(1, 1);
        send_frame(0, BEATS, k); model_frame(k);
        idle();
        wait_outputs(2 * BEATS);
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            g = cap_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_beat: got %s need %s", fmt(g), fmt(e)); end
        end
        checks++;
        if (cap_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d extra beats, %0d missing", cap_q.size(), exp_q.size());
        end
        cap_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int k, r; beat_t g, e; beat_t keep_q[$];
        fill_random(0, 31);
        send_frame(0, BEATS, k); model_frame(k);
        fill_random(0, 31);
        send_frame(0, 10, k);
        @(posedge clk); #1;
        rstn = 1'b0; valid_in = 1'b0; r = cyc;
        foreach (exp_q[i]) if (int'(exp_q[i].cyc) < r) keep_q.push_back(exp_q[i]);
        exp_q = keep_q;
        @(negedge clk);
        checks++;
        if ({valid_out, sof_out, eof_out, exp_out, pack(dout_re), pack(dout_im)} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got valid=%b exp=%0d re=%h im=%h need all 0", valid_out, exp_out, pack(dout_re), pack(dout_im));
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        fill_random(0, 31);
        send_frame(0, BEATS, k); idle(); model_frame(k);
        wait_outputs(exp_q.size());
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            g = cap_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL midreset_beat: got %s need %s", fmt(g), fmt(e)); end
        end
        checks++;
        if (cap_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL midreset_count: got %0d extra beats, %0d missing", cap_q.size(), exp_q.size());
        end
        cap_q.delete(); exp_q.delete();
    endtask

    initial begin
        din_re = '{default: '0};
        din_im = '{default: '0};
        test_reset();
        test_uniform();
        test_mixed();
        test_saturate();
        test_random_gaps(2, 3);
        test_random_gaps(1, 2);
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
